// File: rtl/channel_mean_pkg.sv
// Shared types and sizing for the per-frame channel mean stage.
// Sizing defaults, the derived accumulator width and the FSM state encoding.
package channel_mean_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int CNT_W_DEF = 20;
    localparam int ACC_W_DEF = PIX_W_DEF + CNT_W_DEF;
    localparam int STEP_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/channel_mean_if.sv
// Pixel stream in, per-frame channel means out.
// The slave modport is the statistics block, the master modport is the pixel source and result sink.
interface channel_mean_if
    import channel_mean_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
);
    logic             valid_i;
    logic             sof_i;
    logic             eof_i;
    logic [PIX_W-1:0] r_i;
    logic [PIX_W-1:0] g_i;
    logic [PIX_W-1:0] b_i;
    logic [PIX_W-1:0] r_mean_o;
    logic [PIX_W-1:0] g_mean_o;
    logic [PIX_W-1:0] b_mean_o;
    logic             valid_o;
    logic             busy_o;

    modport slave (
        input  valid_i, sof_i, eof_i, r_i, g_i, b_i,
        output r_mean_o, g_mean_o, b_mean_o, valid_o, busy_o
    );

    modport master (
        output valid_i, sof_i, eof_i, r_i, g_i, b_i,
        input  r_mean_o, g_mean_o, b_mean_o, valid_o, busy_o
    );
endinterface

// File: rtl/channel_div.sv
// Restoring divider datapath for one channel: one quotient bit per enabled cycle, MSB first.
// quot_o is the quotient including the bit decided this cycle, so the parent can register it on the last step.
module channel_div
    import channel_mean_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = PIX_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [ACC_W-1:0]  sum_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [PIX_W-1:0]  quot_o
);
    logic [ACC_W-1:0] rem_q, rem_d, rem_src, trial;
    logic [PIX_W-1:0] q_q, q_d;

    // The first step divides straight from the sum so no extra load cycle is needed.
    always_comb begin
        rem_src = load_i ? sum_i : rem_q;
        trial   = ACC_W'(cnt_i) << step_i;
        rem_d   = rem_src;
        q_d     = load_i ? '0 : q_q;
        if (rem_src >= trial) begin
            rem_d        = rem_src - trial;
            q_d[step_i]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            q_q   <= '0;
        end else if (en_i) begin
            rem_q <= rem_d;
            q_q   <= q_d;
        end
    end

    assign quot_o = q_d;
endmodule

// File: rtl/channel_mean.sv
// Accumulates R/G/B sums and a pixel count per frame, then serially divides to produce 8-bit means.
// Latency 8 cycles from eof acceptance to valid_o; input is ignored while busy_o is high.
module channel_mean
    import channel_mean_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    channel_mean_if.slave pix
);
    localparam int ACC_W = PIX_W + CNT_W;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PIX_W - 1);

    state_t            state_q;
    logic [ACC_W-1:0]  r_sum_q, g_sum_q, b_sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STEP_W-1:0] step_q;
    logic [PIX_W-1:0]  r_mean_q, g_mean_q, b_mean_q;
    logic              valid_q;

    logic              div_en, div_load;
    logic [PIX_W-1:0]  r_quot, g_quot, b_quot;

    assign div_en   = (state_q == ST_DIV);
    assign div_load = div_en && (step_q == STEP_LAST);

    channel_div #(.PIX_W(PIX_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_div_r (
        .clk(clk), .rst(rst), .en_i(div_en), .load_i(div_load), .step_i(step_q),
        .sum_i(r_sum_q), .cnt_i(cnt_q), .quot_o(r_quot)
    );
    channel_div #(.PIX_W(PIX_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_div_g (
        .clk(clk), .rst(rst), .en_i(div_en), .load_i(div_load), .step_i(step_q),
        .sum_i(g_sum_q), .cnt_i(cnt_q), .quot_o(g_quot)
    );
    channel_div #(.PIX_W(PIX_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_div_b (
        .clk(clk), .rst(rst), .en_i(div_en), .load_i(div_load), .step_i(step_q),
        .sum_i(b_sum_q), .cnt_i(cnt_q), .quot_o(b_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            r_sum_q  <= '0;
            g_sum_q  <= '0;
            b_sum_q  <= '0;
            cnt_q    <= '0;
            step_q   <= '0;
            r_mean_q <= '0;
            g_mean_q <= '0;
            b_mean_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pix.valid_i && pix.sof_i) begin
                        r_sum_q <= ACC_W'(pix.r_i);
                        g_sum_q <= ACC_W'(pix.g_i);
                        b_sum_q <= ACC_W'(pix.b_i);
                        cnt_q   <= CNT_W'(1);
                        step_q  <= STEP_LAST;
                        state_q <= pix.eof_i ? ST_DIV : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (pix.valid_i) begin
                        if (pix.sof_i) begin
                            r_sum_q <= ACC_W'(pix.r_i);
                            g_sum_q <= ACC_W'(pix.g_i);
                            b_sum_q <= ACC_W'(pix.b_i);
                            cnt_q   <= CNT_W'(1);
                        end else if (cnt_q != CNT_MAX) begin
                            // A saturated count drops pixels so the sums stay consistent with it.
                            r_sum_q <= r_sum_q + ACC_W'(pix.r_i);
                            g_sum_q <= g_sum_q + ACC_W'(pix.g_i);
                            b_sum_q <= b_sum_q + ACC_W'(pix.b_i);
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                        if (pix.eof_i) begin
                            step_q  <= STEP_LAST;
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    step_q <= step_q - STEP_W'(1);
                    if (step_q == '0) begin
                        r_mean_q <= r_quot;
                        g_mean_q <= g_quot;
                        b_mean_q <= b_quot;
                        valid_q  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pix.r_mean_o = r_mean_q;
    assign pix.g_mean_o = g_mean_q;
    assign pix.b_mean_o = b_mean_q;
    assign pix.valid_o  = valid_q;
    assign pix.busy_o   = (state_q == ST_DIV);
endmodule

// File: tb/tb_channel_mean.sv
// Directed bench for channel_mean: frame means, timing of valid_o/busy_o, restart, busy input drop, reset abort.
module tb_channel_mean;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    channel_mean_if #(.PIX_W(8)) pif ();

    channel_mean dut (
        .clk (clk),
        .rst (rst),
        .pix (pif)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic sof, input logic eof, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pif.valid_i = 1'b1;
        pif.sof_i   = sof;
        pif.eof_i   = eof;
        pif.r_i     = r;
        pif.g_i     = g;
        pif.b_i     = b;
        tick();
        pif.valid_i = 1'b0;
        pif.sof_i   = 1'b0;
        pif.eof_i   = 1'b0;
    endtask

    // Called just after the edge that accepted eof; whatever inputs are driven stay held during DIV.
    task automatic wait_result(input string tag, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        int busy_cnt;
        int early_vld;
        busy_cnt  = 0;
        early_vld = 0;
        for (int i = 0; i < 8; i++) begin
            if (pif.busy_o === 1'b1) busy_cnt++;
            if (pif.valid_o !== 1'b0) early_vld++;
            tick();
        end
        pif.valid_i = 1'b0;
        pif.sof_i   = 1'b0;
        pif.eof_i   = 1'b0;
        chk({tag, "_busy_cycles"}, busy_cnt, 8);
        chk({tag, "_early_valid"}, early_vld, 0);
        chk({tag, "_valid"}, pif.valid_o, 1);
        chk({tag, "_busy_done"}, pif.busy_o, 0);
        chk({tag, "_r"}, pif.r_mean_o, er);
        chk({tag, "_g"}, pif.g_mean_o, eg);
        chk({tag, "_b"}, pif.b_mean_o, eb);
        tick();
        chk({tag, "_valid_pulse"}, pif.valid_o, 0);
        chk({tag, "_idle_after"}, pif.busy_o, 0);
        chk({tag, "_r_hold"}, pif.r_mean_o, er);
    endtask

    initial begin
        pif.valid_i = 1'b0;
        pif.sof_i   = 1'b0;
        pif.eof_i   = 1'b0;
        pif.r_i     = '0;
        pif.g_i     = '0;
        pif.b_i     = '0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", pif.valid_o, 0);
        chk("rst_busy", pif.busy_o, 0);
        chk("rst_r", pif.r_mean_o, 0);
        chk("rst_g", pif.g_mean_o, 0);
        chk("rst_b", pif.b_mean_o, 0);

        // 4-pixel frame: 100/4, 1020/4, 1/4
        send(1'b1, 1'b0, 8'd10, 8'd255, 8'd0);
        send(1'b0, 1'b0, 8'd20, 8'd255, 8'd0);
        send(1'b0, 1'b0, 8'd30, 8'd255, 8'd0);
        send(1'b0, 1'b1, 8'd40, 8'd255, 8'd1);
        wait_result("four_px", 8'd25, 8'd255, 8'd0);

        send(1'b1, 1'b1, 8'd7, 8'd128, 8'd200);
        wait_result("single_px", 8'd7, 8'd128, 8'd200);

        // Bubbles carry garbage data with valid_i low: 4/3, 9/3, 1/3
        send(1'b1, 1'b0, 8'd1, 8'd3, 8'd0);
        pif.r_i = 8'd99; pif.g_i = 8'd99; pif.b_i = 8'd99;
        tick();
        send(1'b0, 1'b0, 8'd1, 8'd3, 8'd0);
        pif.r_i = 8'd250; pif.eof_i = 1'b1;
        tick();
        pif.eof_i = 1'b0;
        tick();
        send(1'b0, 1'b1, 8'd2, 8'd3, 8'd1);
        wait_result("bubbles", 8'd1, 8'd3, 8'd0);

        send(1'b1, 1'b0, 8'd200, 8'd200, 8'd200);
        send(1'b0, 1'b0, 8'd200, 8'd200, 8'd200);
        send(1'b1, 1'b0, 8'd4, 8'd6, 8'd8);
        send(1'b0, 1'b1, 8'd4, 8'd6, 8'd8);
        wait_result("restart", 8'd4, 8'd6, 8'd8);

        // Pixels (including sof+eof) held throughout DIV must be ignored: 102/2, 121/2, 140/2
        send(1'b1, 1'b0, 8'd50, 8'd60, 8'd70);
        send(1'b0, 1'b1, 8'd52, 8'd61, 8'd70);
        pif.valid_i = 1'b1; pif.sof_i = 1'b1; pif.eof_i = 1'b1;
        pif.r_i = 8'd255; pif.g_i = 8'd0; pif.b_i = 8'd255;
        wait_result("busy_ignore", 8'd51, 8'd60, 8'd70);

        // Reset lands on the 4th DIV edge
        send(1'b1, 1'b0, 8'd9, 8'd9, 8'd9);
        send(1'b0, 1'b1, 8'd9, 8'd9, 8'd9);
        chk("abort_busy_pre", pif.busy_o, 1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", pif.busy_o, 0);
        chk("abort_valid", pif.valid_o, 0);
        chk("abort_r", pif.r_mean_o, 0);
        chk("abort_g", pif.g_mean_o, 0);
        chk("abort_b", pif.b_mean_o, 0);
        begin
            int late_vld;
            late_vld = 0;
            for (int i = 0; i < 10; i++) begin
                if (pif.valid_o !== 1'b0) late_vld++;
                tick();
            end
            chk("abort_no_valid", late_vld, 0);
        end

        send(1'b1, 1'b0, 8'd100, 8'd50, 8'd0);
        send(1'b0, 1'b1, 8'd102, 8'd51, 8'd1);
        wait_result("post_abort", 8'd101, 8'd50, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
